mem_read_burst: RTL and testbench

Burst read engine for the READ path. On `start_i` it issues `cnt_val_i` single-beat reads to memory from consecutive word addresses. It buffers the returned data in a small FIFO and streams it out over a valid/ready interface. The running beat-issue count `cnt_o` is exported so the neighbouring counter FSM can use it directly as its `cnt_i` progress input.

---
 rtl/mem_read_burst_if.sv | 29 ++
 rtl/mem_read_burst.sv | 160 ++++++++++++++++
 tb/tb_mem_read_burst.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_burst_if.sv
// Read-path bus bundle: the single-beat memory read port plus the
// valid/ready output stream. The engine drives the master side.
//
// Handshake: a stream beat transfers on a rising edge where m_valid_o and
// m_ready_i are both high. Once m_valid_o is raised, it and m_data_o/m_last_o
// stay stable until that transfer happens. The memory port has no
// handshake: rd_data_i is valid exactly one cycle after rd_en_o.
interface mem_read_burst_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  rd_en_o;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic [DATA_WIDTH-1:0] rd_data_i;
    logic                  m_valid_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_last_o;
    logic                  m_ready_i;

    modport master (
        output rd_en_o, rd_addr_o, m_valid_o, m_data_o, m_last_o,
        input  rd_data_i, m_ready_i
    );

    modport slave (
        input  rd_en_o, rd_addr_o, m_valid_o, m_data_o, m_last_o,
        output rd_data_i, m_ready_i
    );
endinterface

// File: rtl/mem_read_burst.sv
// Burst read engine: issues cnt_val single-beat reads from consecutive word
// addresses, buffers returning data in a small FIFO and streams it out.
// Reads are only issued while the FIFO has room for every outstanding beat,
// so the buffer can never overflow regardless of consumer backpressure.
module mem_read_burst #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  cnt_val_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic [1:0]            dbg_state_o,
    mem_read_burst_if.master      bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0]  cnt_val_q, cnt_val_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  beat_q, beat_d;
    logic                  inflight_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         fifo_count_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic rd_en;
    logic room;
    logic push;
    logic pop;
    logic m_valid;
    logic m_last;

    // Outstanding beats = buffered + the one whose data arrives next cycle.
    assign room    = ({1'b0, fifo_count_q} + {{CW{1'b0}}, inflight_q})
                     < (CW+1)'(FIFO_DEPTH);
    assign m_valid = (fifo_count_q != '0);
    assign m_last  = m_valid && (beat_q == cnt_val_q - CNT_WIDTH'(1));
    assign push    = inflight_q;
    assign pop     = m_valid && bus.m_ready_i;

    // Next-state, capture and issue logic for the burst FSM.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        cnt_val_d = cnt_val_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        rd_en     = 1'b0;

        if (pop) begin
            beat_d = beat_q + CNT_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d    = base_addr_i;
                    cnt_val_d = cnt_val_i;
                    cnt_d     = '0;
                    beat_d    = '0;
                    state_d   = (cnt_val_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_en = room;
                if (rd_en) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == cnt_val_q - CNT_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Burst state and captured request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            cnt_val_q <= '0;
            cnt_q     <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            cnt_val_q <= cnt_val_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
        end
    end

    // FIFO bookkeeping; inflight marks a read whose data lands this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            inflight_q <= rd_en;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers gate use.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr_q] <= bus.rd_data_i;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign cnt_o         = cnt_q;
    assign dbg_state_o   = state_q;
    assign bus.rd_en_o   = rd_en;
    assign bus.rd_addr_o = base_q + ADDR_WIDTH'(cnt_q) * WORD_BYTES;
    assign bus.m_valid_o = m_valid;
    assign bus.m_data_o  = m_valid ? fifo_mem[rd_ptr_q] : '0;
    assign bus.m_last_o  = m_last;
endmodule

// File: tb/tb_mem_read_burst.sv
// Bench for mem_read_burst: a memory model answering every read one cycle
// later with a data word derived from its address, a randomly or explicitly
// stalled consumer, and a scoreboard fed by a burst-level reference model.
module tb_mem_read_burst;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CNTW = 8;

    logic            clk;
    logic            rst;
    logic            start_i;
    logic [AW-1:0]   base_addr_i;
    logic [CNTW-1:0] cnt_val_i;
    logic            busy_o;
    logic            done_o;
    logic [CNTW-1:0] cnt_o;
    logic [1:0]      dbg_state_o;

    mem_read_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    mem_read_burst #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CNTW), .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .cnt_val_i   (cnt_val_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cnt_o       (cnt_o),
        .dbg_state_o (dbg_state_o),
        .bus         (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int issued   = 0;
    int stall_left = 0;
    bit rand_ready = 0;

    logic [AW-1:0] addr_exp_q[$];
    logic [DW-1:0] exp_q[$];
    logic          last_q[$];

    logic          held_valid = 1'b0;
    logic [DW-1:0] held_data  = '0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // ---------------- memory model ----------------
    initial begin
        logic          en;
        logic [AW-1:0] a;
        bus_if.rd_data_i = '0;
        forever begin
            @(negedge clk);
            en = bus_if.rd_en_o;
            a  = bus_if.rd_addr_o;
            @(posedge clk);
            #1;
            bus_if.rd_data_i = en ? mem_fn(a) : DW'($urandom);
        end
    end

    // ---------------- consumer ready driver ----------------
    initial begin
        bus_if.m_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus_if.m_ready_i = 1'b0;
                stall_left--;
            end else begin
                bus_if.m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (bus_if.rd_en_o) begin
                issued++;
                if (addr_exp_q.size() == 0) check("rd_extra", 64'(1), 64'(0));
                else check("rd_addr", 64'(bus_if.rd_addr_o), 64'(addr_exp_q.pop_front()));
            end
            if (bus_if.m_last_o && !bus_if.m_valid_o) check("last_no_valid", 64'(1), 64'(0));
            if (held_valid) begin
                check("hold_valid", 64'(bus_if.m_valid_o), 64'(1));
                check("hold_data", 64'(bus_if.m_data_o), 64'(held_data));
            end
            if (bus_if.m_valid_o && bus_if.m_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("beat_extra", 64'(1), 64'(0));
                end else begin
                    check("beat_data", 64'(bus_if.m_data_o), 64'(exp_q.pop_front()));
                    check("beat_last", 64'(bus_if.m_last_o), 64'(last_q.pop_front()));
                end
            end
            held_valid = bus_if.m_valid_o && !bus_if.m_ready_i;
            held_data  = bus_if.m_data_o;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic start_burst(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i * 4);
            addr_exp_q.push_back(a);
            exp_q.push_back(mem_fn(a));
            last_q.push_back(i == n - 1);
        end
        start_i     = 1'b1;
        base_addr_i = base;
        cnt_val_i   = CNTW'(n);
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        base_addr_i = AW'($urandom);
        cnt_val_i   = CNTW'($urandom);
        check("busy_after_start", 64'(busy_o), 64'(1));
    endtask

    task automatic wait_done(input int n, input int exp_lat);
        int cyc;
        cyc = 0;
        while (!done_o && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_seen", 64'(done_o), 64'(1));
        if (exp_lat >= 0) check("done_latency", 64'(cyc), 64'(exp_lat));
        check("cnt_at_done", 64'(cnt_o), 64'(n));
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done_o), 64'(0));
        check("busy_idle", 64'(busy_o), 64'(0));
        check("cnt_hold", 64'(cnt_o), 64'(n));
        check("sb_drained", 64'(exp_q.size() + addr_exp_q.size()), 64'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},   64'(busy_o), 64'(0));
        check({tag, "_done"},   64'(done_o), 64'(0));
        check({tag, "_cnt"},    64'(cnt_o), 64'(0));
        check({tag, "_rd_en"},  64'(bus_if.rd_en_o), 64'(0));
        check({tag, "_rd_addr"},64'(bus_if.rd_addr_o), 64'(0));
        check({tag, "_valid"},  64'(bus_if.m_valid_o), 64'(0));
        check({tag, "_data"},   64'(bus_if.m_data_o), 64'(0));
        check({tag, "_last"},   64'(bus_if.m_last_o), 64'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int iss0;
        rst = 1'b1;
        start_i = 1'b0;
        base_addr_i = '0;
        cnt_val_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic burst, full throughput.
        start_burst(32'h0000_0100, 4);
        wait_done(4, 6);

        // Back-to-back zero-length burst straight out of IDLE.
        start_burst(32'h0000_0500, 0);
        wait_done(0, 0);

        // Address wrap.
        start_burst(32'hFFFF_FFF8, 3);
        wait_done(3, 5);

        // Backpressure: consumer stalled while 8 beats are requested.
        stall_left = 11;
        bus_if.m_ready_i = 1'b0;
        iss0 = issued;
        start_burst(32'h0000_2000, 8);
        repeat (8) @(posedge clk);
        #1;
        check("bp_issued", 64'(issued - iss0), 64'(4));
        check("bp_valid", 64'(bus_if.m_valid_o), 64'(1));
        wait_done(8, -1);

        // Start pulsed mid-burst with a different request is ignored.
        start_burst(32'h0000_3000, 6);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        base_addr_i = 32'hDEAD_0000;
        cnt_val_i = 8'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(6, 6);

        // Reset one cycle after the first read issue.
        start_burst(32'h0000_4000, 8);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("rst_mid");
        rst = 1'b0;
        addr_exp_q.delete();
        exp_q.delete();
        last_q.delete();
        @(posedge clk);
        #1;
        start_burst(32'h0000_5000, 2);
        wait_done(2, 4);

        // Randomized bursts with random consumer backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            int n;
            n = (k == 4) ? 0 : int'($urandom_range(1, 12));
            start_burst(AW'($urandom), n);
            wait_done(n, -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        rand_ready = 1'b0;
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
